// File: rtl/riscv_pkg.sv
// Shared core definitions used by the pipeline hazard logic.
package riscv_pkg;
  localparam int REG_ADDR_WIDTH = 5;
  localparam int MULDIV_LATENCY_DEFAULT = 8;

  typedef enum logic [0:0] {HZ_RUN, HZ_MD_BUSY} hz_state_e;
endpackage

// File: rtl/hazard_unit.sv
// Stall/flush controller for hazards forwarding cannot cover: load-use,
// multi-cycle MUL/DIV occupancy of EX, and EX-resolved control redirects.
module hazard_unit
  import riscv_pkg::*;
#(
  parameter int MULDIV_LATENCY = MULDIV_LATENCY_DEFAULT,
  parameter int PERF_WIDTH     = 32
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [REG_ADDR_WIDTH-1:0] id_rs1_addr,
  input  logic [REG_ADDR_WIDTH-1:0] id_rs2_addr,
  input  logic                      id_rs1_used,
  input  logic                      id_rs2_used,
  input  logic [REG_ADDR_WIDTH-1:0] id_ex_rd_addr,
  input  logic                      id_ex_reg_wr,
  input  logic                      id_ex_mem_rd,
  input  logic                      id_ex_muldiv,
  input  logic                      ex_redirect,
  output logic                      pc_en,
  output logic                      if_id_en,
  output logic                      id_ex_en,
  output logic                      if_id_flush,
  output logic                      id_ex_flush,
  output logic                      ex_mem_bubble,
  output logic                      muldiv_busy,
  output logic [PERF_WIDTH-1:0]     stall_cycles
);
  localparam int CNT_W = (MULDIV_LATENCY > 2) ? $clog2(MULDIV_LATENCY) : 1;
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(MULDIV_LATENCY - 2);

  hz_state_e        state;
  logic [CNT_W-1:0] md_cnt;
  logic             load_use;

  assign load_use = id_ex_mem_rd & id_ex_reg_wr & (id_ex_rd_addr != '0) &
                    ((id_rs1_used & (id_rs1_addr == id_ex_rd_addr)) |
                     (id_rs2_used & (id_rs2_addr == id_ex_rd_addr)));

  assign muldiv_busy = (state == HZ_MD_BUSY);

  always_comb begin
    pc_en         = 1'b1;
    if_id_en      = 1'b1;
    id_ex_en      = 1'b1;
    if_id_flush   = 1'b0;
    id_ex_flush   = 1'b0;
    ex_mem_bubble = 1'b0;
    if (!rst) begin
      unique case (state)
        HZ_RUN: begin
          if (id_ex_muldiv) begin
            pc_en         = 1'b0;
            if_id_en      = 1'b0;
            id_ex_en      = 1'b0;
            ex_mem_bubble = 1'b1;
          end else if (ex_redirect) begin
            // The ID instruction is squashed, so any load-use on it is moot.
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
          end else if (load_use) begin
            pc_en       = 1'b0;
            if_id_en    = 1'b0;
            id_ex_flush = 1'b1;
          end
        end
        HZ_MD_BUSY: begin
          // md_cnt == 0 is the release cycle: the op moves on to MEM.
          if (md_cnt != '0) begin
            pc_en         = 1'b0;
            if_id_en      = 1'b0;
            id_ex_en      = 1'b0;
            ex_mem_bubble = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= HZ_RUN;
      md_cnt       <= '0;
      stall_cycles <= '0;
    end else begin
      if (!pc_en) stall_cycles <= stall_cycles + 1'b1;
      unique case (state)
        HZ_RUN: begin
          if (id_ex_muldiv) begin
            state  <= HZ_MD_BUSY;
            md_cnt <= CNT_INIT;
          end
        end
        HZ_MD_BUSY: begin
          if (md_cnt == '0) state <= HZ_RUN;
          else              md_cnt <= md_cnt - 1'b1;
        end
        default: state <= HZ_RUN;
      endcase
    end
  end

  a_no_redirect_when_busy: assert property (@(posedge clk) disable iff (rst)
    !(muldiv_busy && ex_redirect));
  a_flush_pair: assert property (@(posedge clk) disable iff (rst)
    if_id_flush |-> id_ex_flush);

endmodule
